blackjack_round_ctrl: RTL and testbench

Round sequencer for the BlackJack game. It sits between `userInput` (player commands), the card source (rank handshake) and the display/score logic. It deals the opening hand and gives the turn to the player. It then plays the dealer by the fixed stand-on-17 rule and resolves the winner. It also keeps the soft/hard running totals for both hands.

---
 rtl/blackjack_round_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_ctrl.sv
// Round sequencer for BlackJack: deals the opening hand, hands the turn to the
// player, plays the dealer by the stand rule and resolves the winner.
module blackjack_round_ctrl #(
    parameter int DEALER_STAND = 17,
    parameter int TOTAL_W      = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_dealButtonPushed,
    input  logic               i_ready,
    input  logic [1:0]         i_command,
    output logic               o_turnIndicator,
    output logic               o_cardReq,
    input  logic               i_cardAck,
    input  logic [3:0]         i_cardRank,
    output logic [TOTAL_W-1:0] o_playerTotal,
    output logic [TOTAL_W-1:0] o_dealerTotal,
    output logic [TOTAL_W-1:0] o_playerCards,
    output logic [TOTAL_W-1:0] o_dealerCards,
    output logic [1:0]         o_result,
    output logic               o_roundDone,
    output logic [2:0]         o_dbgState
);

    localparam logic [1:0] COMMAND_NONE  = 2'd0;
    localparam logic [1:0] COMMAND_HIT   = 2'd1;
    localparam logic [1:0] COMMAND_STAND = 2'd2;
    localparam logic [TOTAL_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAL,
        S_PLAYER_TURN,
        S_PLAYER_DRAW,
        S_DEALER_TURN,
        S_DEALER_DRAW,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic               p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [TOTAL_W-1:0] p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
    logic [1:0]         deal_idx_q, deal_idx_d;
    logic [1:0]         result_q, result_d;
    logic               turn_q, req_q, done_q;

    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        best_total = (ace && (hard <= 5'd11)) ? hard + 5'd10 : hard;
    endfunction

    // Card handshake: a card moves on a rising edge where the request (decoded
    // from a card-taking state) and i_cardAck are both high; ranks outside 1..13 are dropped.
    logic       card_state, card_take, rank_ok, rank_ace;
    logic [4:0] rank_val;
    assign card_state = (state_q == S_DEAL) || (state_q == S_PLAYER_DRAW) ||
                        (state_q == S_DEALER_DRAW);
    assign rank_ok    = (i_cardRank >= 4'd1) && (i_cardRank <= 4'd13);
    assign rank_ace   = (i_cardRank == 4'd1);
    assign rank_val   = (i_cardRank > 4'd10) ? 5'd10 : {1'b0, i_cardRank};
    assign card_take  = card_state && i_cardAck && rank_ok;

    logic [4:0]         p_best, d_best, p_hard_add, d_hard_add, p_best_add;
    logic               p_ace_add, d_ace_add;
    logic [TOTAL_W-1:0] p_cnt_inc, d_cnt_inc;
    logic               cmd_valid;
    assign p_best     = best_total(p_hard_q, p_ace_q);
    assign d_best     = best_total(d_hard_q, d_ace_q);
    assign p_hard_add = p_hard_q + rank_val;
    assign d_hard_add = d_hard_q + rank_val;
    assign p_ace_add  = p_ace_q | rank_ace;
    assign d_ace_add  = d_ace_q | rank_ace;
    assign p_best_add = best_total(p_hard_add, p_ace_add);
    assign p_cnt_inc  = (p_cnt_q == CNT_MAX) ? p_cnt_q : p_cnt_q + TOTAL_W'(1);
    assign d_cnt_inc  = (d_cnt_q == CNT_MAX) ? d_cnt_q : d_cnt_q + TOTAL_W'(1);
    assign cmd_valid  = i_ready && (i_command != COMMAND_NONE);

    always_comb begin
        state_d    = state_q;
        p_hard_d   = p_hard_q;
        d_hard_d   = d_hard_q;
        p_ace_d    = p_ace_q;
        d_ace_d    = d_ace_q;
        p_cnt_d    = p_cnt_q;
        d_cnt_d    = d_cnt_q;
        deal_idx_d = deal_idx_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_dealButtonPushed) begin
                    p_hard_d   = '0;
                    d_hard_d   = '0;
                    p_ace_d    = 1'b0;
                    d_ace_d    = 1'b0;
                    p_cnt_d    = '0;
                    d_cnt_d    = '0;
                    deal_idx_d = '0;
                    result_d   = '0;
                    state_d    = S_DEAL;
                end
            end
            S_DEAL: begin
                if (card_take) begin
                    deal_idx_d = deal_idx_q + 2'd1;
                    if (!deal_idx_q[0]) begin
                        p_hard_d = p_hard_add;
                        p_ace_d  = p_ace_add;
                        p_cnt_d  = p_cnt_inc;
                    end else begin
                        d_hard_d = d_hard_add;
                        d_ace_d  = d_ace_add;
                        d_cnt_d  = d_cnt_inc;
                    end
                    // The last dealt card is the dealer's, so the player's hand is already final.
                    if (deal_idx_q == 2'd3) begin
                        state_d = (p_best == 5'd21) ? S_DEALER_TURN : S_PLAYER_TURN;
                    end
                end
            end
            S_PLAYER_TURN: begin
                if (cmd_valid) begin
                    if (i_command == COMMAND_HIT) begin
                        state_d = S_PLAYER_DRAW;
                    end else if (i_command == COMMAND_STAND) begin
                        state_d = S_DEALER_TURN;
                    end
                end
            end
            S_PLAYER_DRAW: begin
                if (card_take) begin
                    p_hard_d = p_hard_add;
                    p_ace_d  = p_ace_add;
                    p_cnt_d  = p_cnt_inc;
                    if (p_best_add > 5'd21) begin
                        state_d = S_RESOLVE;
                    end else if (p_best_add == 5'd21) begin
                        state_d = S_DEALER_TURN;
                    end else begin
                        state_d = S_PLAYER_TURN;
                    end
                end
            end
            S_DEALER_TURN: begin
                state_d = (int'(d_best) < DEALER_STAND) ? S_DEALER_DRAW : S_RESOLVE;
            end
            S_DEALER_DRAW: begin
                if (card_take) begin
                    d_hard_d = d_hard_add;
                    d_ace_d  = d_ace_add;
                    d_cnt_d  = d_cnt_inc;
                    state_d  = S_DEALER_TURN;
                end
            end
            S_RESOLVE: begin
                if (p_best > 5'd21) begin
                    result_d = 2'd2;
                end else if (d_best > 5'd21) begin
                    result_d = 2'd1;
                end else if (p_best > d_best) begin
                    result_d = 2'd1;
                end else if (p_best < d_best) begin
                    result_d = 2'd2;
                end else begin
                    result_d = 2'd3;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            p_hard_q   <= '0;
            d_hard_q   <= '0;
            p_ace_q    <= 1'b0;
            d_ace_q    <= 1'b0;
            p_cnt_q    <= '0;
            d_cnt_q    <= '0;
            deal_idx_q <= '0;
            result_q   <= '0;
            turn_q     <= 1'b0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_hard_q   <= p_hard_d;
            d_hard_q   <= d_hard_d;
            p_ace_q    <= p_ace_d;
            d_ace_q    <= d_ace_d;
            p_cnt_q    <= p_cnt_d;
            d_cnt_q    <= d_cnt_d;
            deal_idx_q <= deal_idx_d;
            result_q   <= result_d;
            turn_q     <= (state_d == S_PLAYER_TURN);
            req_q      <= (state_d == S_DEAL) || (state_d == S_PLAYER_DRAW) ||
                          (state_d == S_DEALER_DRAW);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign o_turnIndicator = turn_q;
    assign o_cardReq       = req_q;
    assign o_roundDone     = done_q;
    assign o_result        = result_q;
    assign o_playerTotal   = TOTAL_W'(p_best);
    assign o_dealerTotal   = TOTAL_W'(d_best);
    assign o_playerCards   = p_cnt_q;
    assign o_dealerCards   = d_cnt_q;
    assign o_dbgState      = state_q;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Randomized round-level bench for blackjack_round_ctrl, checked against a
// hand-based reference model (card lists, best-total and winner rules).
module tb_blackjack_round_ctrl;

    localparam int TW = 5;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_HIT   = 2'd1;
    localparam logic [1:0] CMD_STAND = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          deal = 1'b0, ready = 1'b0, ack = 1'b0;
    logic [1:0]    cmd = CMD_NONE;
    logic [3:0]    rank = 4'd0;
    logic          turn, req, done;
    logic [TW-1:0] p_total, d_total, p_cards, d_cards;
    logic [1:0]    result;
    logic [2:0]    dbg_state;

    blackjack_round_ctrl #(.DEALER_STAND(17), .TOTAL_W(TW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_dealButtonPushed (deal),
        .i_ready            (ready),
        .i_command          (cmd),
        .o_turnIndicator    (turn),
        .o_cardReq          (req),
        .i_cardAck          (ack),
        .i_cardRank         (rank),
        .o_playerTotal      (p_total),
        .o_dealerTotal      (d_total),
        .o_playerCards      (p_cards),
        .o_dealerCards      (d_cards),
        .o_result           (result),
        .o_roundDone        (done),
        .o_dbgState         (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    int p_q[$];
    int d_q[$];
    int deck_q[$];
    int g_stall = 0;
    int g_illegal = 0;

    // scoreboard / reference model
    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int best_of(input int q[$]);
        int hard;
        bit ace;
        hard = 0;
        ace = 1'b0;
        foreach (q[i]) begin
            hard += (q[i] > 10) ? 10 : q[i];
            if (q[i] == 1) ace = 1'b1;
        end
        return (ace && hard <= 11) ? hard + 10 : hard;
    endfunction

    function automatic int exp_result();
        int p, d;
        p = best_of(p_q);
        d = best_of(d_q);
        if (p > 21) return 2;
        if (d > 21) return 1;
        if (p > d) return 1;
        if (p < d) return 2;
        return 3;
    endfunction

    task automatic check_hands(input string tag);
        check_eq({tag, "_ptot"}, int'(p_total), best_of(p_q));
        check_eq({tag, "_dtot"}, int'(d_total), best_of(d_q));
        check_eq({tag, "_pcnt"}, int'(p_cards), p_q.size());
        check_eq({tag, "_dcnt"}, int'(d_cards), d_q.size());
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_turn"}, int'(turn), 0);
        check_eq({tag, "_req"}, int'(req), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_result"}, int'(result), 0);
        check_eq({tag, "_ptot"}, int'(p_total), 0);
        check_eq({tag, "_dtot"}, int'(d_total), 0);
        check_eq({tag, "_pcnt"}, int'(p_cards), 0);
        check_eq({tag, "_dcnt"}, int'(d_cards), 0);
    endtask

    // driver tasks (inputs change on the falling edge, outputs sampled there too)
    task automatic give_card(output int r);
        int st, bad;
        bit ill;
        r = (deck_q.size() > 0) ? deck_q.pop_front() : int'($urandom_range(1, 13));
        st = (g_stall < 0) ? int'($urandom_range(0, 2)) : g_stall;
        ill = (g_illegal == 1) || (g_illegal == 2 && $urandom_range(0, 3) == 0);
        for (int s = 0; s < st; s++) begin
            ack = 1'b0;
            @(negedge clk);
            check_eq("stall_req", int'(req), 1);
            check_hands("stall");
        end
        if (ill) begin
            bad = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(14, 15));
            ack = 1'b1;
            rank = 4'(bad);
            @(negedge clk);
            check_eq("bad_rank_req", int'(req), 1);
            check_hands("bad_rank");
        end
        ack = 1'b1;
        rank = 4'(r);
        @(negedge clk);
        ack = 1'b0;
        rank = 4'd0;
    endtask

    task automatic pt_noise();
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            ready = 1'($urandom_range(0, 1));
            cmd = ready ? CMD_NONE : 2'($urandom_range(0, 3));
            ack = 1'($urandom_range(0, 1));
            rank = 4'($urandom_range(0, 15));
            @(negedge clk);
            ready = 1'b0;
            cmd = CMD_NONE;
            ack = 1'b0;
            rank = 4'd0;
            check_eq("noise_turn", int'(turn), 1);
            check_eq("noise_req", int'(req), 0);
            check_hands("noise");
        end
    endtask

    task automatic play_round(input int thresh, input int stall, input int illegal, input bit poke_deal);
        int r;
        bit bust, hit, poked;
        g_stall = stall;
        g_illegal = illegal;
        p_q.delete();
        d_q.delete();
        deal = 1'b1;
        @(negedge clk);
        deal = 1'b0;
        check_eq("deal_req", int'(req), 1);
        check_eq("deal_result_clr", int'(result), 0);
        check_eq("deal_done_clr", int'(done), 0);
        check_hands("deal_clr");
        for (int i = 0; i < 4; i++) begin
            check_eq("deal_req_hi", int'(req), 1);
            give_card(r);
            if (i % 2 == 0) p_q.push_back(r);
            else d_q.push_back(r);
            check_hands("deal_card");
        end
        check_eq("deal_req_drop", int'(req), 0);
        bust = 1'b0;
        poked = 1'b0;
        if (best_of(p_q) != 21) begin
            forever begin
                check_eq("turn_on", int'(turn), 1);
                pt_noise();
                if (poke_deal && !poked) begin
                    deal = 1'b1;
                    @(negedge clk);
                    deal = 1'b0;
                    poked = 1'b1;
                    check_eq("poke_turn", int'(turn), 1);
                    check_eq("poke_req", int'(req), 0);
                    check_hands("poke");
                end
                hit = best_of(p_q) < thresh;
                ready = 1'b1;
                cmd = hit ? CMD_HIT : CMD_STAND;
                @(negedge clk);
                ready = 1'b0;
                cmd = CMD_NONE;
                check_eq("turn_off", int'(turn), 0);
                if (!hit) break;
                check_eq("hit_req", int'(req), 1);
                give_card(r);
                p_q.push_back(r);
                check_hands("hit_card");
                if (best_of(p_q) > 21) begin
                    bust = 1'b1;
                    break;
                end
                if (best_of(p_q) == 21) break;
            end
        end else begin
            check_eq("bj_no_turn", int'(turn), 0);
        end
        if (!bust) begin
            check_eq("dt_req_lo", int'(req), 0);
            check_eq("dt_turn_lo", int'(turn), 0);
            while (best_of(d_q) < 17) begin
                @(negedge clk);
                check_eq("dealer_req", int'(req), 1);
                give_card(r);
                d_q.push_back(r);
                check_hands("dealer_card");
                check_eq("dealer_eval_req", int'(req), 0);
            end
            @(negedge clk);
        end
        check_eq("resolve_done_lo", int'(done), 0);
        check_eq("resolve_req_lo", int'(req), 0);
        @(negedge clk);
        check_eq("round_done", int'(done), 1);
        check_eq("result", int'(result), exp_result());
        check_hands("final");
        repeat (2) @(negedge clk);
        check_eq("hold_done", int'(done), 1);
        check_eq("hold_result", int'(result), exp_result());
        check_hands("hold");
    endtask

    task automatic reset_mid_deal();
        int r;
        g_stall = 0;
        g_illegal = 0;
        p_q.delete();
        d_q.delete();
        deal = 1'b1;
        @(negedge clk);
        deal = 1'b0;
        for (int i = 0; i < 2; i++) begin
            give_card(r);
            if (i == 0) p_q.push_back(r);
            else d_q.push_back(r);
            check_hands("rst_deal_card");
        end
        ack = 1'b1;
        rank = 4'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        ack = 1'b0;
        rank = 4'd0;
        @(negedge clk);
        check_all_zero("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst_release");
        p_q.delete();
        d_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        deck_q = '{10, 9, 7, 8};            // 17 vs 17, stand -> push
        play_round(17, 0, 0, 1'b0);
        deck_q = '{1, 5, 13, 6, 6};         // player 21, dealer 11 draws to 17
        play_round(17, 0, 0, 1'b0);
        deck_q = '{10, 7, 6, 10, 9};        // player 16 hits 9 -> bust
        play_round(17, 0, 0, 1'b0);
        deck_q = '{10, 1, 9, 6};            // dealer soft 17 stands
        play_round(17, 0, 0, 1'b0);
        deck_q = '{10, 1, 9, 5, 13, 4};     // dealer soft 16 -> hard 16 -> 20
        play_round(17, 0, 0, 1'b0);
        deck_q = '{2, 3, 4, 5, 4};          // long stalls and a dropped rank on every card
        play_round(11, 5, 1, 1'b0);
        deck_q.delete();

        reset_mid_deal();
        play_round(15, 0, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            play_round(int'($urandom_range(12, 18)), -1, 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
